fetch_entry_buffer: RTL
=======================

FETCH_ENTRY_BUFFER -- requirements
Module: fetch_entry_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of fetch entries buffered; power of two, >= 2.
REQ-002 SHALL have parameter VLEN, default 39; virtual address width.
REQ-003 SHALL have parameter CAUSE_W, default 64; exception cause width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  controller flush; discards all held entries.
REQ-007 SHALL have port valid_i  input  1  upstream (realigner) entry valid.
REQ-008 SHALL have port ready_o  output  1  buffer accepts the upstream entry.
REQ-009 SHALL have port addr_i  input  VLEN  instruction PC.
REQ-010 SHALL have port instr_i  input  32  raw instruction bits; may be compressed in [15:0].
REQ-011 SHALL have ports bp_taken_i  input  1 and bp_target_i  input  VLEN  branch prediction.
REQ-012 SHALL have ports ex_valid_i  input  1 and ex_cause_i  input  CAUSE_W  fetch exception.
REQ-013 SHALL have port fetch_entry_valid_o  output  1  head entry valid toward the ID stage.
REQ-014 SHALL have port fetch_entry_ready_i  input  1  ID stage accepts the head entry.
REQ-015 SHALL have ports addr_o, instr_o, bp_taken_o, bp_target_o, ex_valid_o, ex_cause_o  output  same widths as inputs  head entry fields.
REQ-016 SHALL have port count_o  output  $clog2(DEPTH+1)  number of held entries.

Function
REQ-017 SHALL store entries in a circular buffer with read pointer, write pointer, and count registers; pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 SHALL define a push as valid_i && ready_o and a pop as fetch_entry_valid_o && fetch_entry_ready_i.
REQ-019 SHALL drive fetch_entry_valid_o = (count != 0); the head fields SHALL come from the read-pointer slot; all head fields SHALL be 0 when count == 0.
REQ-020 SHALL have no fall-through: an entry pushed in cycle N SHALL first appear on the outputs in cycle N+1.
REQ-021 SHALL drive ready_o = (count < DEPTH) && (state == RUN) && !flush_i; a pop in the same cycle SHALL NOT raise ready_o when full.
REQ-022 SHALL, on a simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-023 SHALL implement FSM states RUN and EX_HOLD.
REQ-024 RUN -> EX_HOLD SHALL occur on a push with ex_valid_i=1.
REQ-025 In EX_HOLD, ready_o SHALL be 0, so the excepting entry is the youngest held entry.
REQ-026 EX_HOLD -> RUN SHALL occur on a pop with count == 1.
REQ-027 SHALL, on flush_i=1, set count to 0, both pointers to 0, and state to RUN at the next edge; any push or pop in that cycle SHALL be discarded; fetch_entry_valid_o SHALL still reflect the pre-flush count during the flush cycle.
REQ-028 SHALL keep count_o equal to the count register; count SHALL never exceed DEPTH nor underflow.
REQ-029 SHALL hold the head fields stable while fetch_entry_valid_o=1 and fetch_entry_ready_i=0.

Reset
REQ-030 SHALL, with rst_ni=0, immediately force count=0, pointers=0, state=RUN, fetch_entry_valid_o=0, all head fields=0, count_o=0.
REQ-031 SHALL drive ready_o=1 in the first cycle after reset release (flush_i=0).
REQ-032 Storage array contents need not be reset; they SHALL never be visible while count == 0.
REQ-033 SHALL, when reset is asserted mid-transfer, discard all entries, with no push or pop completing in that cycle.

Verification
REQ-034 Latency (DEPTH=4), fetch_entry_ready_i=0: push addr 0x80000000/instr 0x00000013 in cycle 0 -> cycle 1: fetch_entry_valid_o=1, addr_o=0x80000000, count_o=1.
REQ-035 Full: 4 pushes with ID stalled -> ready_o=0, count_o=4; pop plus valid_i the same cycle -> no push, count_o=3 next cycle; ready_o=1.
REQ-036 Wrap: 6 pushes interleaved with pops, PCs 0x0,0x4,...,0x14 -> popped in order 0x0..0x14, none lost or duplicated.
REQ-037 Exception: push PC 0x100 with ex_valid_i=1, cause 12 -> ready_o=0 until that entry is popped, then ready_o=1; ex_cause_o=12 at pop.
REQ-038 Flush: count_o=3, state EX_HOLD, flush_i=1 with simultaneous push -> next cycle count_o=0, fetch_entry_valid_o=0, ready_o=1, pushed entry absent.
REQ-039 Async reset: rst_ni dropped mid-cycle with count_o=2 -> fetch_entry_valid_o=0 and count_o=0 before the next clock edge.

Source files
------------

// File: rtl/fetch_entry_buffer.sv
// fetch_entry_buffer
//   Circular buffer of decoded-fetch entries between the instruction
//   realigner and the ID stage. An entry pushed in one cycle is visible on
//   the head outputs from the next cycle on; there is no fall-through path.
//   When an entry carrying a fetch exception is accepted, the buffer stops
//   accepting until that entry has been consumed, so the excepting entry is
//   always the youngest one held.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                discard every held entry at the next edge
//   valid_i / ready_o      upstream entry handshake
//   addr_i, instr_i,
//   bp_taken_i, bp_target_i,
//   ex_valid_i, ex_cause_i upstream entry fields
//   fetch_entry_valid_o /
//   fetch_entry_ready_i    head entry handshake toward ID
//   addr_o ... ex_cause_o  head entry fields, all zero while empty
//   count_o                number of held entries
module fetch_entry_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned VLEN    = 39,
    parameter int unsigned CAUSE_W = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [VLEN-1:0]              addr_i,
    input  logic [31:0]                  instr_i,
    input  logic                         bp_taken_i,
    input  logic [VLEN-1:0]              bp_target_i,
    input  logic                         ex_valid_i,
    input  logic [CAUSE_W-1:0]           ex_cause_i,
    output logic                         fetch_entry_valid_o,
    input  logic                         fetch_entry_ready_i,
    output logic [VLEN-1:0]              addr_o,
    output logic [31:0]                  instr_o,
    output logic                         bp_taken_o,
    output logic [VLEN-1:0]              bp_target_o,
    output logic                         ex_valid_o,
    output logic [CAUSE_W-1:0]           ex_cause_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [VLEN-1:0]    addr;
        logic [31:0]        instr;
        logic               bp_taken;
        logic [VLEN-1:0]    bp_target;
        logic               ex_valid;
        logic [CAUSE_W-1:0] ex_cause;
    } entry_t;

    typedef enum logic {
        RUN,
        EX_HOLD
    } state_e;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    state_e             state_q;

    logic               push;
    logic               pop;
    entry_t             head;

    assign ready_o             = (count_q < CNT_W'(DEPTH)) && (state_q == RUN) && !flush_i;
    assign fetch_entry_valid_o = (count_q != '0);
    assign push                = valid_i && ready_o;
    assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;
    assign count_o             = count_q;

    // Head is masked while empty so stale storage never leaks out.
    always_comb begin
        head = '0;
        if (fetch_entry_valid_o) begin
            head = mem[rd_ptr_q];
        end
    end

    assign addr_o      = head.addr;
    assign instr_o     = head.instr;
    assign bp_taken_o  = head.bp_taken;
    assign bp_target_o = head.bp_target;
    assign ex_valid_o  = head.ex_valid;
    assign ex_cause_o  = head.ex_cause;

    // Storage needs no reset: it is only observable through count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{
                addr:      addr_i,
                instr:     instr_i,
                bp_taken:  bp_taken_i,
                bp_target: bp_target_i,
                ex_valid:  ex_valid_i,
                ex_cause:  ex_cause_i
            };
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps DEPTH-1 -> 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end

            // Popping the last entry in EX_HOLD is popping the excepting one.
            if (push && ex_valid_i) begin
                state_q <= EX_HOLD;
            end else if (pop && (count_q == CNT_W'(1))) begin
                state_q <= RUN;
            end
        end
    end

endmodule
